instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the current fetch address, issues requests to instruction memory and tracks outstanding requests.
- Buffers returned instructions, each tagged with its PC, in a small FIFO toward decode.
- Generates the PC advance enable (backpressure); discards in-flight fetches on a branch/flush.

Parameters:
- ADDR_WIDTH, 32, fetch address width; equals the core memory address width.
- DATA_WIDTH, 32, instruction width.
- DEPTH, 2, instruction FIFO entries; also the maximum number of outstanding requests. Power of two, ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- pc_i  in  ADDR_WIDTH  current fetch address from the PC
- pc_valid_i  in  1  pc_i is valid to fetch
- pc_ready_o  out  1  PC may advance this cycle (request accepted)
- flush_i  in  1  branch taken; drop everything fetched or in flight
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  ADDR_WIDTH  memory request address
- imem_gnt_i  in  1  memory accepted request this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  DATA_WIDTH  response data
- instr_valid_o  out  1  instruction available to decode
- instr_o  out  DATA_WIDTH  instruction
- instr_pc_o  out  ADDR_WIDTH  PC of instr_o
- instr_ready_i  in  1  decode consumes the instruction

Behaviour:
- Reset (asynchronous, active-low; mid-operation reset behaves the same):
  - FIFO empty, outstanding=0, discard=0.
  - instr_valid_o=0, instr_o=0, instr_pc_o=0.
  - imem_req_o=0, pc_ready_o=0.
- Credit rule: credits = DEPTH − (fifo_count + outstanding).
- Request path (combinational):
  - imem_req_o = pc_valid_i & !flush_i & (credits>0).
  - imem_addr_o = pc_i; pc_i[1:0] passed unmodified.
  - Handshake: request accepted when imem_req_o & imem_gnt_i.
  - pc_ready_o = imem_req_o & imem_gnt_i.
  - No request may be issued without a free credit, so the FIFO can never overflow.
- Tag queue: on each accepted request, push pc_i into a DEPTH-entry address queue.
- Responses:
  - Memory returns responses in order, earliest 1 cycle after grant.
  - On imem_rvalid_i with discard>0: drop the data, discard−1, pop the tag queue.
  - On imem_rvalid_i with discard=0 and outstanding>0: write {rdata, popped tag} into the FIFO; outstanding−1.
  - On imem_rvalid_i with outstanding=0 and discard=0: protocol error; ignore the response, no state change.
- Output side:
  - instr_valid_o = FIFO not empty; instr_o/instr_pc_o = FIFO head (registered storage).
  - Pop on instr_valid_o & instr_ready_i.
  - FIFO is non-bypassing: grant in cycle N → rvalid ≥N+1 → instr_valid_o ≥N+2.
- Counter updates:
  - outstanding increments on grant and decrements on a kept response; same cycle → unchanged.
  - Push and pop of the FIFO in the same cycle are both allowed, including when full (full & pop & push legal).
- Flush (flush_i=1 for a cycle):
  - FIFO cleared; instr_valid_o=0 next cycle.
  - discard ← outstanding, minus 1 if a non-discarded rvalid arrives in the same cycle; that response is dropped.
  - outstanding ← 0.
  - No request is issued in the flush cycle.
  - Responses still pending from an earlier flush keep being discarded; discard accumulates.
  - A pop by decode in the flush cycle has no effect.
- Post-flush requests:
  - New requests may issue from the cycle after the flush.
  - Credits count discard as outstanding: credits = DEPTH − (fifo_count + outstanding + discard).
- Wrap-around: FIFO and tag-queue pointers are log2(DEPTH) bits and wrap naturally; counters are log2(DEPTH)+1 bits.

Test Plan:
- Basic fetch (DEPTH=2): pc_i=0x00 then 0x04, gnt=1, rvalid 1 cycle later with 0x00000013/0x00100093, instr_ready_i=1 → instr 0x00000013 @PC 0x00 at cycle 2, then 0x00100093 @PC 0x04 at cycle 3; pc_ready_o high in cycles 0 and 1.
- Backpressure: instr_ready_i=0, fetch 0x00 and 0x04 → FIFO full; pc_ready_o=0 and imem_req_o=0 while pc_valid_i=1; assert ready → 0x00 pops, exactly one new request (0x08) follows next cycle.
- Grant stall: imem_gnt_i=0 for 3 cycles with pc_i=0x10 → imem_req_o held 1, addr held 0x10, pc_ready_o=0; grant on cycle 3 → one request, one instruction with PC 0x10.
- Flush with 2 in flight: grant 0x20 and 0x24, flush_i before any rvalid, pc_i=0x100 → both later responses dropped, no instr_valid_o; 0x100 issues only after a credit frees; its instruction is delivered with PC 0x100.
- Flush coincident with rvalid and a full FIFO → FIFO empty next cycle, the coincident response is not delivered, discard = remaining outstanding.
- Reset mid-operation: assert rst_n=0 with 2 outstanding and 1 buffered → all outputs 0 immediately; after release, a stray rvalid is ignored and a fetch at 0x00 works normally.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
// Sits between the program counter and decode: issues fetch requests to
// instruction memory, tracks how many are in flight, pairs each returned word
// with the PC it was fetched from and buffers the pair in a small FIFO.
// A slot is reserved for every request at issue time (buffered + in flight +
// still-to-be-discarded never exceeds DEPTH), so the FIFO cannot overflow and
// memory never has to be stalled on the response side.
// DEPTH must be a power of two and at least 2.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  pc_valid_i,
  output logic                  pc_ready_o,
  input  logic                  flush_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  // Pointers index DEPTH entries and wrap naturally; counters need one more
  // bit so that "full" (== DEPTH) is representable.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit again for the sum of three counters in the credit check.
  localparam int SUM_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]      fifo_count_reg,  fifo_count_next;
  logic [CNT_W-1:0]      outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]      discard_reg,     discard_next;

  logic [PTR_W-1:0]      fifo_wr_ptr_reg, fifo_wr_ptr_next;
  logic [PTR_W-1:0]      fifo_rd_ptr_reg, fifo_rd_ptr_next;
  logic [PTR_W-1:0]      tag_wr_ptr_reg,  tag_wr_ptr_next;
  logic [PTR_W-1:0]      tag_rd_ptr_reg,  tag_rd_ptr_next;

  // Instruction FIFO: returned word plus the PC it belongs to.
  logic [DATA_WIDTH-1:0] fifo_data_reg [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc_reg   [DEPTH];
  // Tag queue: PC of every request still owed a response (kept or discarded).
  logic [ADDR_WIDTH-1:0] tag_pc_reg    [DEPTH];

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0]      slots_used;
  logic                  credit_avail;
  logic                  req_accept;
  logic                  rsp_discard;
  logic                  rsp_kept;
  logic                  tag_pop;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DEPTH-1:0]      fifo_wr_en;
  logic [DEPTH-1:0]      tag_wr_en;
  logic [ADDR_WIDTH-1:0] tag_head;

  // Responses still to be discarded occupy a slot just like live requests:
  // they will come back and pop the tag queue, so they must be paid for.
  assign slots_used   = SUM_W'(fifo_count_reg) + SUM_W'(outstanding_reg)
                      + SUM_W'(discard_reg);
  assign credit_avail = (slots_used < SUM_W'(DEPTH));

  // Request is never raised during reset, in a flush cycle, or without a slot.
  assign imem_req_o  = rst_n & pc_valid_i & ~flush_i & credit_avail;
  assign imem_addr_o = pc_i;
  assign req_accept  = imem_req_o & imem_gnt_i;
  assign pc_ready_o  = req_accept;

  // A response belongs to a flushed request while discard is non-zero
  // (responses are in order, so the oldest ones are the stale ones).
  // A response with nothing owed is a protocol error and is ignored outright.
  assign rsp_discard = imem_rvalid_i & (discard_reg != '0);
  assign rsp_kept    = imem_rvalid_i & (discard_reg == '0) & (outstanding_reg != '0);
  assign tag_pop     = rsp_discard | rsp_kept;
  assign tag_head    = tag_pc_reg[tag_rd_ptr_reg];

  // A kept response arriving together with a flush is dropped, and a decode
  // pop in the flush cycle is meaningless because the FIFO is being cleared.
  assign fifo_push   = rsp_kept & ~flush_i;
  assign fifo_pop    = instr_valid_o & instr_ready_i & ~flush_i;

  // Output side reads the FIFO head straight from its storage registers.
  assign instr_valid_o = (fifo_count_reg != '0);
  assign instr_o       = fifo_data_reg[fifo_rd_ptr_reg];
  assign instr_pc_o    = fifo_pc_reg[fifo_rd_ptr_reg];

  // Per-entry write enables for the FIFO and the tag queue.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign fifo_wr_en[gi] = fifo_push  & (fifo_wr_ptr_reg == PTR_W'(gi));
    assign tag_wr_en[gi]  = req_accept & (tag_wr_ptr_reg  == PTR_W'(gi));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // In-flight bookkeeping: grants add, kept responses retire, flush moves
  // whatever is still owed over to the discard count (accumulating onto any
  // discards left from an earlier flush).
  always_comb begin
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (req_accept) begin
      outstanding_next = outstanding_next + CNT_ONE;
    end
    if (rsp_kept) begin
      outstanding_next = outstanding_next - CNT_ONE;
    end
    if (rsp_discard) begin
      discard_next = discard_next - CNT_ONE;
    end
    if (flush_i) begin
      discard_next     = discard_next + outstanding_next;
      outstanding_next = '0;
    end
  end

  // FIFO occupancy and pointers; a flush empties the FIFO by snapping the
  // read pointer onto the write pointer (no push happens in a flush cycle).
  always_comb begin
    fifo_count_next  = fifo_count_reg;
    fifo_wr_ptr_next = fifo_wr_ptr_reg;
    fifo_rd_ptr_next = fifo_rd_ptr_reg;
    if (fifo_push) begin
      fifo_count_next  = fifo_count_next + CNT_ONE;
      fifo_wr_ptr_next = fifo_wr_ptr_reg + PTR_ONE;
    end
    if (fifo_pop) begin
      fifo_count_next  = fifo_count_next - CNT_ONE;
      fifo_rd_ptr_next = fifo_rd_ptr_reg + PTR_ONE;
    end
    if (flush_i) begin
      fifo_count_next  = '0;
      fifo_rd_ptr_next = fifo_wr_ptr_reg;
    end
  end

  // Tag queue pointers: push on every accepted request, pop on every
  // response that is owed (whether it is kept or discarded).
  always_comb begin
    tag_wr_ptr_next = tag_wr_ptr_reg;
    tag_rd_ptr_next = tag_rd_ptr_reg;
    if (req_accept) begin
      tag_wr_ptr_next = tag_wr_ptr_reg + PTR_ONE;
    end
    if (tag_pop) begin
      tag_rd_ptr_next = tag_rd_ptr_reg + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Counters and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      tag_wr_ptr_reg  <= '0;
      tag_rd_ptr_reg  <= '0;
    end else begin
      fifo_count_reg  <= fifo_count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      fifo_wr_ptr_reg <= fifo_wr_ptr_next;
      fifo_rd_ptr_reg <= fifo_rd_ptr_next;
      tag_wr_ptr_reg  <= tag_wr_ptr_next;
      tag_rd_ptr_reg  <= tag_rd_ptr_next;
    end
  end

  // FIFO storage: a kept response is written together with the oldest tag.
  // Cleared on reset so instr_o / instr_pc_o read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_pc_reg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_wr_en[i]) begin
          fifo_data_reg[i] <= imem_rdata_i;
          fifo_pc_reg[i]   <= tag_head;
        end
      end
    end
  end

  // Tag queue storage: remembers the fetch address of each accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_pc_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (tag_wr_en[i]) begin
          tag_pc_reg[i] <= pc_i;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------

  // Reserved slots never exceed the FIFO capacity.
  assert property (@(posedge clk) disable iff (!rst_n)
                   slots_used <= SUM_W'(DEPTH));

  // The FIFO occupancy itself stays within bounds.
  assert property (@(posedge clk) disable iff (!rst_n)
                   fifo_count_reg <= CNT_W'(DEPTH));

endmodule
